// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state codes, owner codes and latency-counter sizing shared by mem_port_arbiter
package mem_arb_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;
  function automatic int cnt_w(input int latency);
    return $clog2(latency + 1);
  endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch (i_*), data (d_*) and memory (mem_*) buses; slave = arbiter side, master = pipeline/memory side
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic i_ack;
  logic d_req;
  logic d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic d_ack;
  logic mem_cs;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  modport slave (
    input i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_rdata, i_ack, d_rdata, d_ack, mem_cs, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input i_rdata, i_ack, d_rdata, d_ack, mem_cs, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/arb_age_counter.sv
// arb_age_counter: saturating up-counter with synchronous clear; ports clk, rst, clr, inc, cnt
module arb_age_counter #(
  parameter int LIMIT = 4,
  parameter int W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (inc && cnt != W'(LIMIT)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory between fetch and data ports (clk, rst, bus: mem_port_arbiter_if.slave, pipe_stall); ARB_AGING_EN adds fetch aging
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LATENCY = 2,
  parameter int AGE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  mem_port_arbiter_if.slave bus,
  output logic pipe_stall
);
  localparam int CW = cnt_w(LATENCY);
  logic [1:0] state;
  logic owner;
  logic rd;
  logic [CW-1:0] cnt;
  logic pick_i;
  logic pick_rd;
  logic issue;
`ifdef ARB_AGING_EN
  localparam int AW = $clog2(AGE_LIMIT + 1);
  logic [AW-1:0] age;
  arb_age_counter #(.LIMIT(AGE_LIMIT), .W(AW)) u_age (
    .clk(clk),
    .rst(rst),
    .clr(state == IDLE && (!bus.i_req || pick_i)),
    .inc(state == IDLE && bus.i_req && bus.d_req && !pick_i),
    .cnt(age)
  );
  assign pick_i = bus.i_req && (!bus.d_req || age == AW'(AGE_LIMIT));
`else
  logic unused_age;
  assign unused_age = ^AGE_LIMIT;
  assign pick_i = bus.i_req && !bus.d_req;
`endif
  assign issue = state == IDLE && (bus.i_req || bus.d_req);
  assign pick_rd = pick_i || !bus.d_we;
  assign pipe_stall = (bus.i_req & ~bus.i_ack) | (bus.d_req & ~bus.d_ack);
  // reads wait LATENCY cycles after the mem_cs cycle for mem_rdata; writes finish at once
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= OWN_I;
      rd <= 1'b0;
      cnt <= '0;
      bus.i_ack <= 1'b0;
      bus.d_ack <= 1'b0;
      bus.i_rdata <= '0;
      bus.d_rdata <= '0;
      bus.mem_cs <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.i_ack <= 1'b0;
      bus.d_ack <= 1'b0;
      bus.mem_cs <= issue;
      bus.mem_we <= issue && !pick_i && bus.d_we;
      bus.mem_addr <= !issue ? '0 : pick_i ? bus.i_addr : bus.d_addr;
      bus.mem_wdata <= (issue && !pick_i) ? bus.d_wdata : '0;
      if (issue) begin
        state <= WAIT;
        owner <= pick_i ? OWN_I : OWN_D;
        rd <= pick_rd;
        cnt <= pick_rd ? CW'(LATENCY) : '0;
      end else if (state == WAIT) begin
        if (cnt != '0) cnt <= cnt - 1'b1;
        else begin
          state <= RESP;
          bus.i_ack <= owner == OWN_I;
          bus.d_ack <= owner == OWN_D;
          if (rd && owner == OWN_I) bus.i_rdata <= bus.mem_rdata;
          if (rd && owner == OWN_D) bus.d_rdata <= bus.mem_rdata;
        end
      end else state <= IDLE;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter (LATENCY=2 directed, LATENCY=1 sweep)
module tb_mem_port_arbiter;
  typedef struct { logic [31:0] data; bit chk_data; int cyc; } ack_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; int cyc; } iss_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall_a, stall_b;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int n_bi = 0, n_bd = 0, ack_bi = 0, ack_bd = 0;
  ack_t qi[$], qd[$], qbi[$], qbd[$];
  iss_t qm[$];
  ack_t ea, eb;
  iss_t em;
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  bit wr_a [256];
  bit wr_b [256];
  logic [31:0] pa0 = '0, pa1 = '0, pb0 = '0;
  logic [31:0] ref_m [16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(2), .AGE_LIMIT(2)) dut_a (
    .clk(clk), .rst(rst), .bus(a.slave), .pipe_stall(stall_a)
  );
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1), .AGE_LIMIT(2)) dut_b (
    .clk(clk), .rst(rst), .bus(b.slave), .pipe_stall(stall_b)
  );

  function automatic logic [31:0] init_word(input logic [31:0] ad);
    case (ad)
      32'h40:  return 32'hDEADBEEF;
      32'h44:  return 32'hCAFEF00D;
      32'h48:  return 32'h0BADF00D;
      32'h80:  return 32'h000055AA;
      default: return {16'hB00B, ad[15:0]};
    endcase
  endfunction

  always @(posedge clk) begin
    if (a.mem_cs && a.mem_we) begin
      mem_a[a.mem_addr[9:2]] <= a.mem_wdata;
      wr_a[a.mem_addr[9:2]] <= 1'b1;
    end
    pa0 <= wr_a[a.mem_addr[9:2]] ? mem_a[a.mem_addr[9:2]] : init_word(a.mem_addr);
    pa1 <= pa0;
    if (b.mem_cs && b.mem_we) begin
      mem_b[b.mem_addr[9:2]] <= b.mem_wdata;
      wr_b[b.mem_addr[9:2]] <= 1'b1;
    end
    pb0 <= wr_b[b.mem_addr[9:2]] ? mem_b[b.mem_addr[9:2]] : init_word(b.mem_addr);
  end
  assign a.mem_rdata = pa1;
  assign b.mem_rdata = pb0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    tests++;
    fails++;
    $display("FAIL %s: unexpected or missing event (cycle %0d)", name, cyc);
  endtask

  always @(negedge clk) begin
    if (a.i_ack) begin
      if (qi.size() == 0) flag("i_ack_spurious");
      else begin
        ea = qi.pop_front();
        if (ea.chk_data) check("i_rdata", a.i_rdata, ea.data);
        if (ea.cyc >= 0) check("i_ack_cycle", 32'(cyc), 32'(ea.cyc));
      end
    end
    if (a.d_ack) begin
      if (qd.size() == 0) flag("d_ack_spurious");
      else begin
        ea = qd.pop_front();
        if (ea.chk_data) check("d_rdata", a.d_rdata, ea.data);
        if (ea.cyc >= 0) check("d_ack_cycle", 32'(cyc), 32'(ea.cyc));
      end
    end
    if (a.mem_cs) begin
      if (qm.size() == 0) flag("mem_cs_spurious");
      else begin
        em = qm.pop_front();
        check("mem_we", 32'(a.mem_we), 32'(em.we));
        check("mem_addr", a.mem_addr, em.addr);
        check("mem_wdata", a.mem_wdata, em.wdata);
        if (em.cyc >= 0) check("mem_cs_cycle", 32'(cyc), 32'(em.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (b.i_ack) begin
      ack_bi++;
      if (qbi.size() == 0) flag("b_i_ack_spurious");
      else begin
        eb = qbi.pop_front();
        check("b_i_rdata", b.i_rdata, eb.data);
      end
    end
    if (b.d_ack) begin
      ack_bd++;
      if (qbd.size() == 0) flag("b_d_ack_spurious");
      else begin
        eb = qbd.pop_front();
        if (eb.chk_data) check("b_d_rdata", b.d_rdata, eb.data);
      end
    end
  end

  task automatic a_i(input logic [31:0] ad, input int stall_end);
    a.i_req = 1'b1;
    a.i_addr = ad;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (stall_end >= 0) check("i_stall", 32'(stall_a), 32'(cyc < stall_end));
      if (a.i_ack) break;
      if (n == 49) flag("i_ack_timeout");
    end
    @(posedge clk);
    #1 a.i_req = 1'b0;
    a.i_addr = '0;
  endtask

  task automatic a_d(input logic we, input logic [31:0] ad, input logic [31:0] wd, input int stall_end);
    a.d_req = 1'b1;
    a.d_we = we;
    a.d_addr = ad;
    a.d_wdata = wd;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (stall_end >= 0) check("d_stall", 32'(stall_a), 32'(cyc < stall_end));
      if (a.d_ack) break;
      if (n == 49) flag("d_ack_timeout");
    end
    @(posedge clk);
    #1 a.d_req = 1'b0;
    a.d_we = 1'b0;
    a.d_addr = '0;
    a.d_wdata = '0;
  endtask

  task automatic b_i(input logic [31:0] ad);
    b.i_req = 1'b1;
    b.i_addr = ad;
    n_bi++;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (b.i_ack) break;
      if (n == 29) flag("b_i_ack_timeout");
    end
    @(posedge clk);
    #1 b.i_req = 1'b0;
  endtask

  task automatic b_d(input logic we, input logic [31:0] ad, input logic [31:0] wd);
    b.d_req = 1'b1;
    b.d_we = we;
    b.d_addr = ad;
    b.d_wdata = wd;
    n_bd++;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (b.d_ack) break;
      if (n == 29) flag("b_d_ack_timeout");
    end
    @(posedge clk);
    #1 b.d_req = 1'b0;
    b.d_we = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, n, kind, ri, rd_i;
    logic we;
    logic [31:0] ia, da, wd;
    a.i_req = 0; a.i_addr = 0; a.d_req = 0; a.d_we = 0; a.d_addr = 0; a.d_wdata = 0;
    b.i_req = 0; b.i_addr = 0; b.d_req = 0; b.d_we = 0; b.d_addr = 0; b.d_wdata = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_i_ack", 32'(a.i_ack), 0);
    check("rst_d_ack", 32'(a.d_ack), 0);
    check("rst_mem_cs", 32'(a.mem_cs), 0);
    check("rst_mem_we", 32'(a.mem_we), 0);
    check("rst_mem_addr", a.mem_addr, 0);
    check("rst_mem_wdata", a.mem_wdata, 0);
    check("rst_i_rdata", a.i_rdata, 0);
    check("rst_d_rdata", a.d_rdata, 0);
    check("rst_stall", 32'(stall_a), 0);
    @(posedge clk);
    #1;
    // single fetch read: mem_cs at t0+1, ack at t0+4
    t0 = cyc;
    qm.push_back('{1'b0, 32'h40, 32'h0, t0 + 1});
    qi.push_back('{32'hDEADBEEF, 1'b1, t0 + 4});
    a_i(32'h40, t0 + 4);
    // single write: ack two cycles after the request, then read it back
    t0 = cyc;
    qm.push_back('{1'b1, 32'h10, 32'h1234, t0 + 1});
    qd.push_back('{32'h0, 1'b0, t0 + 2});
    a_d(1'b1, 32'h10, 32'h1234, t0 + 2);
    t0 = cyc;
    qm.push_back('{1'b0, 32'h10, 32'h0, t0 + 1});
    qi.push_back('{32'h00001234, 1'b1, t0 + 4});
    a_i(32'h10, t0 + 4);
    // simultaneous: data read first (ack t0+4), fetch issued t0+6, ack t0+9
    t0 = cyc;
    qm.push_back('{1'b0, 32'h80, 32'h0, t0 + 1});
    qm.push_back('{1'b0, 32'h44, 32'h0, t0 + 6});
    qd.push_back('{32'h000055AA, 1'b1, t0 + 4});
    qi.push_back('{32'hCAFEF00D, 1'b1, t0 + 9});
    fork
      a_i(32'h44, -1);
      a_d(1'b0, 32'h80, 32'h0, -1);
    join
    // fetch held against back-to-back data writes
    qi.push_back('{32'h0BADF00D, 1'b1, -1});
    for (int k = 0; k < 4; k++) qd.push_back('{32'h0, 1'b0, -1});
    qm.push_back('{1'b1, 32'h100, 32'h1000, -1});
    qm.push_back('{1'b1, 32'h104, 32'h1001, -1});
`ifdef ARB_AGING_EN
    qm.push_back('{1'b0, 32'h48, 32'h0, -1});
    qm.push_back('{1'b1, 32'h108, 32'h1002, -1});
    qm.push_back('{1'b1, 32'h10C, 32'h1003, -1});
`else
    qm.push_back('{1'b1, 32'h108, 32'h1002, -1});
    qm.push_back('{1'b1, 32'h10C, 32'h1003, -1});
    qm.push_back('{1'b0, 32'h48, 32'h0, -1});
`endif
    fork
      a_i(32'h48, -1);
      for (int k = 0; k < 4; k++) a_d(1'b1, 32'h100 + 32'(k) * 4, 32'h1000 + 32'(k), -1);
    join
    // reset during the WAIT phase of a read abandons it
    t0 = cyc;
    qm.push_back('{1'b0, 32'h40, 32'h0, t0 + 1});
    a.i_req = 1'b1;
    a.i_addr = 32'h40;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    a.i_req = 1'b0;
    a.i_addr = '0;
    @(negedge clk);
    check("mid_rst_i_ack", 32'(a.i_ack), 0);
    check("mid_rst_mem_cs", 32'(a.mem_cs), 0);
    check("mid_rst_mem_we", 32'(a.mem_we), 0);
    check("mid_rst_mem_addr", a.mem_addr, 0);
    check("mid_rst_mem_wdata", a.mem_wdata, 0);
    check("mid_rst_i_rdata", a.i_rdata, 0);
    check("mid_rst_d_rdata", a.d_rdata, 0);
    repeat (5) begin
      @(negedge clk);
      check("no_ack_after_rst", 32'(a.i_ack), 0);
    end
    @(posedge clk);
    #1 t0 = cyc;
    qm.push_back('{1'b0, 32'h44, 32'h0, t0 + 1});
    qi.push_back('{32'hCAFEF00D, 1'b1, t0 + 4});
    a_i(32'h44, t0 + 4);
    check("a_queues_empty", 32'(qi.size() + qd.size() + qm.size()), 0);
    // LATENCY=1 sweep against a reference memory
    for (int k = 0; k < 16; k++) ref_m[k] = init_word(32'h200 + 32'(k) * 4);
    n = 0;
    while (n < 100) begin
      kind = (n == 99) ? int'($urandom_range(1, 0)) : int'($urandom_range(2, 0));
      ri = int'($urandom_range(15, 0));
      rd_i = int'($urandom_range(15, 0));
      ia = 32'h200 + 32'(rd_i) * 4;
      da = 32'h200 + 32'(ri) * 4;
      we = 1'($urandom_range(1, 0));
      wd = $urandom;
      if (kind != 0) begin
        qbd.push_back('{ref_m[ri], !we, -1});
        if (we) ref_m[ri] = wd;
      end
      if (kind != 1) qbi.push_back('{ref_m[rd_i], 1'b1, -1});
      fork
        begin if (kind != 1) b_i(ia); end
        begin if (kind != 0) b_d(we, da, wd); end
      join
      n += (kind == 2) ? 2 : 1;
    end
    repeat (4) @(negedge clk);
    check("b_i_one_ack_each", 32'(ack_bi), 32'(n_bi));
    check("b_d_one_ack_each", 32'(ack_bd), 32'(n_bd));
    check("b_queues_empty", 32'(qbi.size() + qbd.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
